imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, is the instruction-memory word-address width (2^ADDR_W words).
REQ-002 Parameter HALT_PC, default 32'h000000ff, is the write-back PC value that marks program end.
REQ-003 Parameter REL_CYC, default 2, is the number of cycles the core stays in reset after loading completes.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 s_valid  in  1  the load-stream word is valid.
REQ-007 s_ready  out  1  the loader accepts the word this cycle.
REQ-008 s_data  in  32  instruction word.
REQ-009 s_last  in  1  the current word is the final word of the program.
REQ-010 imem_we  out  1  instruction-memory write enable.
REQ-011 imem_waddr  out  ADDR_W  word address of the write.
REQ-012 imem_wdata  out  32  write data.
REQ-013 core_rstn  out  1  active-low core reset; low holds the core.
REQ-014 pcW  in  32  write-back-stage PC from the core.
REQ-015 reload  in  1  single-cycle request to restart loading.
REQ-016 halted  out  1  the program reached HALT_PC.
REQ-017 ovf  out  1  the stream exceeded memory capacity (sticky).
REQ-018 word_cnt  out  ADDR_W+1  number of words written in the last load.
REQ-019 run_cyc  out  32  number of core cycles from release to halt.

Function
REQ-020 The FSM states SHALL be LOAD, RELEASE, RUN and HALT, with LOAD as the reset state.
REQ-021 In LOAD: s_ready=1 and core_rstn=0; on s_valid&s_ready, the word is written at the next edge (imem_we=1 for one cycle with the registered address/data), one-cycle latency.
REQ-022 The write address SHALL start at 0 and increment by 1 per accepted word; word_cnt increments with it.
REQ-023 An accepted word with s_last=1 SHALL be written, then the FSM goes LOAD->RELEASE.
REQ-024 An accepted word at address 2^ADDR_W-1 with s_last=0 SHALL be written, set ovf=1, and go LOAD->RELEASE; the address never wraps.
REQ-025 In all states other than LOAD, s_ready=0; valid words are not accepted and not dropped.
REQ-026 RELEASE holds core_rstn=0 for exactly REL_CYC cycles, then goes to RUN; core_rstn=1 from the first RUN cycle.
REQ-027 In RUN, run_cyc increments by 1 every cycle and saturates at 32'hffffffff.
REQ-028 In RUN, when pcW==HALT_PC the FSM goes to HALT at the next edge; halted=1 and run_cyc is frozen there, and core_rstn stays 1.
REQ-029 reload=1 in RELEASE, RUN or HALT SHALL go to LOAD at the next edge: core_rstn=0, clear address, word_cnt, run_cyc, halted and ovf.
REQ-030 reload in LOAD SHALL be ignored; reload has priority over the halt detection in the same cycle.
REQ-031 s_last together with the last address SHALL count as normal termination: ovf=0.

Reset
REQ-032 While rstn=0, the FSM SHALL be in LOAD, with:
- s_ready=0;
- imem_we=0;
- imem_waddr=0;
- imem_wdata=0;
- core_rstn=0;
- halted=0;
- ovf=0;
- word_cnt=0;
- run_cyc=0.
REQ-033 s_ready SHALL rise no earlier than the first clock edge after rstn deasserts.
REQ-034 rstn assertion mid-load or mid-run SHALL abort immediately to the reset values; imem contents are unaffected.

Structure
REQ-035 The FSM state encoding SHALL be a shared-package enum, and the package also holds the NOP constant 32'h00000013.
REQ-036 HALT_PC and the default ADDR_W SHALL be constants in the shared package.
REQ-037 The block SHALL be a single module with no sub-modules, instantiated beside xgriscv_sc and its instruction memory.

Verification
REQ-038 Stream 25 words, last on word 24, with s_valid stalls every 3rd cycle -> imem[0..24] match, word_cnt=25, ovf=0, core_rstn rises exactly REL_CYC cycles after the last write.
REQ-039 Force pcW to 32'h000000ff 40 cycles after release -> halted=1, run_cyc=40, core_rstn stays 1.
REQ-040 With ADDR_W=4, stream 20 words with no s_last -> 16 writes, ovf=1, s_ready=0 afterwards, and the remaining 4 words are held by the source.
REQ-041 Assert reload in RUN at cycle 10 -> the next cycle is LOAD, core_rstn=0, and word_cnt and run_cyc are 0; then reload a 3-word program successfully.
REQ-042 Assert rstn low after word 7 of a load, then release it -> all outputs at reset values, and loading restarts at address 0.
REQ-043 Assert reload in the same cycle as pcW==HALT_PC -> the FSM goes to LOAD and halted stays 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// default constants used by the loader and the core integration around it.
package imem_loader_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned REL_CYC_DEF = 2;

    // Write-back PC that marks the end of a program.
    localparam logic [DATA_W-1:0] HALT_PC_DEF = 32'h0000_00ff;

    // RISC-V canonical NOP (addi x0, x0, 0).
    localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a program as a valid/ready word stream,
// writes it into instruction memory, holds the core in reset while loading,
// releases it, then measures run length until the write-back PC hits HALT_PC.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last   program load stream
//   imem_we/imem_waddr/imem_wdata   instruction-memory write port
//   core_rstn                 active-low reset to the core
//   pcW                       write-back PC observed from the core
//   reload                    one-cycle request to restart loading
//   halted, ovf               program finished / stream overflowed memory
//   word_cnt, run_cyc         words loaded / core cycles from release to halt
//
// REL_CYC must be at least 1.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter logic [31:0] HALT_PC = HALT_PC_DEF,
    parameter int unsigned REL_CYC = REL_CYC_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rstn,
    input  logic [31:0]       pcW,
    input  logic              reload,
    output logic              halted,
    output logic              ovf,
    output logic [ADDR_W:0]   word_cnt,
    output logic [31:0]       run_cyc
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned REL_W = (REL_CYC > 1) ? $clog2(REL_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_CYC - 1);

    state_t            r_state,      w_state;
    logic              r_s_ready,    w_s_ready;
    logic              r_imem_we,    w_imem_we;
    logic [ADDR_W-1:0] r_imem_waddr, w_imem_waddr;
    logic [31:0]       r_imem_wdata, w_imem_wdata;
    logic              r_core_rstn,  w_core_rstn;
    logic              r_halted,     w_halted;
    logic              r_ovf,        w_ovf;
    logic [CNT_W-1:0]  r_word_cnt,   w_word_cnt;
    logic [31:0]       r_run_cyc,    w_run_cyc;
    logic [REL_W-1:0]  r_rel_cnt,    w_rel_cnt;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_LOAD;
            r_s_ready    <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_core_rstn  <= 1'b0;
            r_halted     <= 1'b0;
            r_ovf        <= 1'b0;
            r_word_cnt   <= '0;
            r_run_cyc    <= '0;
            r_rel_cnt    <= '0;
        end else begin
            r_state      <= w_state;
            r_s_ready    <= w_s_ready;
            r_imem_we    <= w_imem_we;
            r_imem_waddr <= w_imem_waddr;
            r_imem_wdata <= w_imem_wdata;
            r_core_rstn  <= w_core_rstn;
            r_halted     <= w_halted;
            r_ovf        <= w_ovf;
            r_word_cnt   <= w_word_cnt;
            r_run_cyc    <= w_run_cyc;
            r_rel_cnt    <= w_rel_cnt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state      = r_state;
        w_s_ready    = r_s_ready;
        w_imem_we    = 1'b0;
        w_imem_waddr = r_imem_waddr;
        w_imem_wdata = r_imem_wdata;
        w_core_rstn  = r_core_rstn;
        w_halted     = r_halted;
        w_ovf        = r_ovf;
        w_word_cnt   = r_word_cnt;
        w_run_cyc    = r_run_cyc;
        w_rel_cnt    = r_rel_cnt;

        if (reload && (r_state != ST_LOAD)) begin
            // Reload wins over halt detection in the same cycle.
            w_state     = ST_LOAD;
            w_s_ready   = 1'b1;
            w_core_rstn = 1'b0;
            w_halted    = 1'b0;
            w_ovf       = 1'b0;
            w_word_cnt  = '0;
            w_run_cyc   = '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    // s_ready rises one edge after reset release.
                    w_s_ready   = 1'b1;
                    w_core_rstn = 1'b0;
                    if (s_valid && r_s_ready) begin
                        // Word count doubles as the next write address.
                        w_imem_we    = 1'b1;
                        w_imem_waddr = r_word_cnt[ADDR_W-1:0];
                        w_imem_wdata = s_data;
                        w_word_cnt   = r_word_cnt + CNT_W'(1);
                        if (s_last || (r_word_cnt == LAST_IDX)) begin
                            w_state   = ST_RELEASE;
                            w_s_ready = 1'b0;
                            w_rel_cnt = '0;
                            // Filling the last slot is only an overflow when the
                            // stream still has more words to send.
                            w_ovf     = !s_last;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (r_rel_cnt == REL_LAST) begin
                        w_state     = ST_RUN;
                        w_core_rstn = 1'b1;
                    end else begin
                        w_rel_cnt = r_rel_cnt + REL_W'(1);
                    end
                end
                ST_RUN: begin
                    if (r_run_cyc != '1) begin
                        w_run_cyc = r_run_cyc + 32'd1;
                    end
                    if (pcW == HALT_PC) begin
                        w_state  = ST_HALT;
                        w_halted = 1'b1;
                    end
                end
                ST_HALT: begin
                    w_halted = 1'b1;
                end
                default: begin
                    w_state = ST_LOAD;
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign imem_we    = r_imem_we;
    assign imem_waddr = r_imem_waddr;
    assign imem_wdata = r_imem_wdata;
    assign core_rstn  = r_core_rstn;
    assign halted     = r_halted;
    assign ovf        = r_ovf;
    assign word_cnt   = r_word_cnt;
    assign run_cyc    = r_run_cyc;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a default instance (ADDR_W=8) for the
// load/release/run/halt/reload flows and an ADDR_W=4 instance for capacity.
module tb_imem_loader;

    localparam logic [31:0] HALT = 32'h0000_00ff;
    localparam int          REL  = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // Instance A (ADDR_W = 8)
    logic        a_valid, a_s_ready, a_last, a_we, a_core_rstn, a_reload, a_halted, a_ovf;
    logic [31:0] a_data, a_wdata, a_pcw, a_run_cyc;
    logic [7:0]  a_waddr;
    logic [8:0]  a_word_cnt;

    // Instance B (ADDR_W = 4)
    logic        b_valid, b_s_ready, b_last, b_we, b_core_rstn, b_reload, b_halted, b_ovf;
    logic [31:0] b_data, b_wdata, b_pcw, b_run_cyc;
    logic [3:0]  b_waddr;
    logic [4:0]  b_word_cnt;

    imem_loader u_dut_a (
        .clk(clk), .rstn(rstn),
        .s_valid(a_valid), .s_ready(a_s_ready), .s_data(a_data), .s_last(a_last),
        .imem_we(a_we), .imem_waddr(a_waddr), .imem_wdata(a_wdata),
        .core_rstn(a_core_rstn), .pcW(a_pcw), .reload(a_reload),
        .halted(a_halted), .ovf(a_ovf), .word_cnt(a_word_cnt), .run_cyc(a_run_cyc)
    );

    imem_loader #(.ADDR_W(4)) u_dut_b (
        .clk(clk), .rstn(rstn),
        .s_valid(b_valid), .s_ready(b_s_ready), .s_data(b_data), .s_last(b_last),
        .imem_we(b_we), .imem_waddr(b_waddr), .imem_wdata(b_wdata),
        .core_rstn(b_core_rstn), .pcW(b_pcw), .reload(b_reload),
        .halted(b_halted), .ovf(b_ovf), .word_cnt(b_word_cnt), .run_cyc(b_run_cyc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: loading flag, words accepted, expected pending writes.
    bit          m_load  = 1'b0;
    int          m_cnt   = 0;
    int          q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] mem_a [0:255];
    logic [31:0] sent  [0:63];

    bit          bm_load = 1'b0;
    int          bm_cnt  = 0;
    int          b_nwr   = 0;
    int          qb_addr[$];
    logic [31:0] qb_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle on A: drive the stream, advance the model, check the write port.
    task automatic step_a(input logic v, input logic [31:0] d, input logic l);
        int          ea;
        logic [31:0] ed;
        chk("a_s_ready", 32'(a_s_ready), 32'(m_load));
        if (a_reload && !m_load) begin
            m_load = 1'b1;
            m_cnt  = 0;
        end else if (v && m_load) begin
            q_addr.push_back(m_cnt);
            q_data.push_back(d);
            m_cnt++;
            if (l || m_cnt == 256) m_load = 1'b0;
        end
        a_valid = v; a_data = d; a_last = l;
        @(negedge clk);
        chk("a_we", 32'(a_we), 32'(q_data.size()));
        if (a_we && q_data.size() != 0) begin
            ea = q_addr.pop_front();
            ed = q_data.pop_front();
            chk("a_waddr", 32'(a_waddr), 32'(ea));
            chk("a_wdata", a_wdata, ed);
            mem_a[a_waddr] = a_wdata;
        end else begin
            q_addr.delete();
            q_data.delete();
        end
    endtask

    task automatic step_b(input logic v, input logic [31:0] d, input logic l);
        int          ea;
        logic [31:0] ed;
        chk("b_s_ready", 32'(b_s_ready), 32'(bm_load));
        if (b_reload && !bm_load) begin
            bm_load = 1'b1;
            bm_cnt  = 0;
        end else if (v && bm_load) begin
            qb_addr.push_back(bm_cnt);
            qb_data.push_back(d);
            bm_cnt++;
            if (l || bm_cnt == 16) bm_load = 1'b0;
        end
        b_valid = v; b_data = d; b_last = l;
        @(negedge clk);
        chk("b_we", 32'(b_we), 32'(qb_data.size()));
        if (b_we && qb_data.size() != 0) begin
            ea = qb_addr.pop_front();
            ed = qb_data.pop_front();
            chk("b_waddr", 32'(b_waddr), 32'(ea));
            chk("b_wdata", b_wdata, ed);
            b_nwr++;
        end else begin
            qb_addr.delete();
            qb_data.delete();
        end
    endtask

    // Send sent[0..n-1]; rl_at pulses reload on that cycle index (-1 = never).
    task automatic load_a(input int n, input bit stall3, input int rl_at, input bit use_last);
        int   k = 0;
        int   g = 0;
        logic v;
        logic acc;
        while (k < n && g < 1000) begin
            v        = stall3 ? 1'(g % 3 != 2) : 1'($urandom_range(0, 3) != 0);
            a_reload = 1'(g == rl_at);
            acc      = v && m_load;
            step_a(v, sent[k], use_last && (k == n - 1));
            if (acc) k++;
            g++;
        end
        a_reload = 1'b0;
        a_valid  = 1'b0;
        chk("a_load_done", 32'(k), 32'(n));
    endtask

    // Count cycles from the last-word write sample until the core is released.
    task automatic wait_release();
        int n = 0;
        while (!a_core_rstn && n < 10) begin
            step_a(1'b1, 32'hdead_beef, 1'b0);
            n++;
        end
        a_valid = 1'b0;
        chk("a_rel_cyc", 32'(n), 32'(REL));
        chk("a_run_start", a_run_cyc, 32'd0);
    endtask

    task automatic chk_rst_a();
        chk("rst_s_ready", 32'(a_s_ready), 32'd0);
        chk("rst_we", 32'(a_we), 32'd0);
        chk("rst_waddr", 32'(a_waddr), 32'd0);
        chk("rst_wdata", a_wdata, 32'd0);
        chk("rst_core_rstn", 32'(a_core_rstn), 32'd0);
        chk("rst_halted", 32'(a_halted), 32'd0);
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        chk("rst_word_cnt", 32'(a_word_cnt), 32'd0);
        chk("rst_run_cyc", a_run_cyc, 32'd0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom;
        if (p == HALT) p = 32'h0000_0100;
        return p;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic v;
        logic acc;

        rstn = 1'b0;
        a_valid = 0; a_data = 0; a_last = 0; a_pcw = 0; a_reload = 0;
        b_valid = 0; b_data = 0; b_last = 0; b_pcw = 0; b_reload = 0;
        repeat (3) @(negedge clk);
        chk_rst_a();
        chk("b_rst_ovf", 32'(b_ovf), 32'd0);

        // Ready must wait for the first edge after reset release.
        rstn = 1'b1;
        #1;
        chk("a_ready_early", 32'(a_s_ready), 32'd0);
        @(negedge clk);
        m_load  = 1'b1;
        bm_load = 1'b1;

        // Capacity overflow on the 16-word instance: 20 words, no s_last.
        k = 0;
        for (int g = 0; g < 40; g++) begin
            v   = 1'(k < 20);
            acc = v && bm_load;
            step_b(v, 32'hb000_0000 + 32'(k), 1'b0);
            if (acc) k++;
        end
        b_valid = 1'b0;
        chk("b_writes", 32'(b_nwr), 32'd16);
        chk("b_ovf", 32'(b_ovf), 32'd1);
        chk("b_word_cnt", 32'(b_word_cnt), 32'd16);
        chk("b_held", 32'(20 - k), 32'd4);

        // Reload B, then fill exactly 16 words with s_last on the last slot.
        b_reload = 1'b1;
        step_b(1'b0, 32'd0, 1'b0);
        b_reload = 1'b0;
        chk("b_rl_ovf", 32'(b_ovf), 32'd0);
        chk("b_rl_word_cnt", 32'(b_word_cnt), 32'd0);
        b_nwr = 0;
        k = 0;
        for (int g = 0; g < 300 && k < 16; g++) begin
            v   = 1'($urandom_range(0, 2) != 0);
            acc = v && bm_load;
            step_b(v, 32'hc000_0000 + 32'(k), 1'(k == 15));
            if (acc) k++;
        end
        repeat (3) step_b(1'b0, 32'd0, 1'b0);
        chk("b_full_writes", 32'(b_nwr), 32'd16);
        chk("b_full_ovf", 32'(b_ovf), 32'd0);
        chk("b_full_word_cnt", 32'(b_word_cnt), 32'd16);

        // 25-word program with a stall every third cycle.
        for (int i = 0; i < 64; i++) sent[i] = $urandom;
        load_a(25, 1'b1, -1, 1'b1);
        wait_release();
        chk("a_word_cnt25", 32'(a_word_cnt), 32'd25);
        chk("a_ovf25", 32'(a_ovf), 32'd0);
        for (int i = 0; i < 25; i++) chk("a_mem", mem_a[i], sent[i]);

        // Halt PC on the 40th run cycle.
        for (int i = 1; i <= 40; i++) begin
            a_pcw = (i == 40) ? HALT : rand_pc();
            step_a(1'b0, 32'd0, 1'b0);
            chk("a_run_cyc", a_run_cyc, 32'(i));
            chk("a_halted_run", 32'(a_halted), 32'(i == 40));
        end
        for (int i = 0; i < 3; i++) begin
            a_pcw = rand_pc();
            step_a(1'b0, 32'd0, 1'b0);
        end
        chk("a_halted", 32'(a_halted), 32'd1);
        chk("a_run_frozen", a_run_cyc, 32'd40);
        chk("a_core_halt", 32'(a_core_rstn), 32'd1);

        // Reload from HALT clears everything.
        a_reload = 1'b1;
        step_a(1'b0, 32'd0, 1'b0);
        a_reload = 1'b0;
        chk("rl_halted", 32'(a_halted), 32'd0);
        chk("rl_core", 32'(a_core_rstn), 32'd0);
        chk("rl_word_cnt", 32'(a_word_cnt), 32'd0);
        chk("rl_run_cyc", a_run_cyc, 32'd0);

        // Reload during RUN at cycle 10.
        for (int i = 0; i < 64; i++) sent[i] = $urandom;
        load_a(5, 1'b0, -1, 1'b1);
        wait_release();
        for (int i = 1; i <= 10; i++) begin
            a_pcw    = rand_pc();
            a_reload = 1'(i == 10);
            step_a(1'b0, 32'd0, 1'b0);
            if (i < 10) chk("rl_run_cnt", a_run_cyc, 32'(i));
        end
        a_reload = 1'b0;
        chk("rlrun_core", 32'(a_core_rstn), 32'd0);
        chk("rlrun_word_cnt", 32'(a_word_cnt), 32'd0);
        chk("rlrun_run_cyc", a_run_cyc, 32'd0);
        chk("rlrun_ready", 32'(a_s_ready), 32'd1);

        // 3-word program; a reload pulse while loading must be ignored.
        for (int i = 0; i < 64; i++) sent[i] = $urandom;
        load_a(3, 1'b0, 1, 1'b1);
        wait_release();
        chk("p3_word_cnt", 32'(a_word_cnt), 32'd3);
        for (int i = 0; i < 3; i++) chk("p3_mem", mem_a[i], sent[i]);

        // Reload coincides with the halt PC: reload wins.
        for (int i = 0; i < 5; i++) begin
            a_pcw = rand_pc();
            step_a(1'b0, 32'd0, 1'b0);
        end
        a_pcw    = HALT;
        a_reload = 1'b1;
        step_a(1'b0, 32'd0, 1'b0);
        a_reload = 1'b0;
        chk("rh_halted", 32'(a_halted), 32'd0);
        chk("rh_core", 32'(a_core_rstn), 32'd0);
        chk("rh_run_cyc", a_run_cyc, 32'd0);
        step_a(1'b0, 32'd0, 1'b0);
        chk("rh_halted_load", 32'(a_halted), 32'd0);
        a_pcw = 32'd0;

        // Reset after word 7 of a load, then restart from address 0.
        for (int i = 0; i < 64; i++) sent[i] = $urandom;
        load_a(7, 1'b0, -1, 1'b0);
        chk("pre_rst_word_cnt", 32'(a_word_cnt), 32'd7);
        rstn = 1'b0;
        #1;
        chk_rst_a();
        m_load = 1'b0;
        m_cnt  = 0;
        q_addr.delete();
        q_data.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        m_load = 1'b1;
        for (int i = 0; i < 64; i++) sent[i] = $urandom;
        load_a(4, 1'b0, -1, 1'b1);
        wait_release();
        chk("post_rst_word_cnt", 32'(a_word_cnt), 32'd4);
        for (int i = 0; i < 4; i++) chk("post_rst_mem", mem_a[i], sent[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
